// File: rtl/glb_read_arbiter.sv
// Round-robin arbiter sharing the single GLB read port among NoC controllers,
// with bounded burst ownership and one-cycle tagged read-data return.
module glb_read_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          glb_re,
  output logic [ADDR_WIDTH-1:0]         glb_addr,
  input  logic [DATA_WIDTH-1:0]         glb_rdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic                          busy
);

  localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [OW-1:0] OWNER_RST = OW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_TOP = BW'(MAX_BURST - 1);

  logic [OW-1:0]      owner_q, owner_d;
  logic               locked_q, locked_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] others;
  logic [OW-1:0]      gidx;
  logic               grant;
  logic               found;
  int unsigned        idx;

  // Grant decision and next-state: continue the burst, rotate, or go idle.
  always_comb begin
    owner_d  = owner_q;
    locked_d = locked_q;
    burst_d  = burst_q;
    gidx     = owner_q;
    grant    = 1'b0;
    found    = 1'b0;
    idx      = 0;
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
    others   = req & ~owner_oh;

    if (reset) begin
      grant = 1'b0;
    end else if (locked_q && req[owner_q] && ((burst_q < BURST_TOP) || (others == '0))) begin
      grant   = 1'b1;
      burst_d = (burst_q == BURST_TOP) ? burst_q : burst_q + BW'(1);
    end else if (|req) begin
      // Search starts just past the owner and wraps back onto it last.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = (32'(owner_q) + k) % NUM_REQ;
        if (!found && req[OW'(idx)]) begin
          found = 1'b1;
          gidx  = OW'(idx);
        end
      end
      grant    = 1'b1;
      owner_d  = gidx;
      burst_d  = '0;
      locked_d = 1'b1;
    end else begin
      locked_d = 1'b0;
      burst_d  = '0;
    end
  end

  always_comb begin
    gnt       = '0;
    gnt[gidx] = grant;
    glb_re    = grant;
    glb_addr  = grant ? addr_in[32'(gidx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    rdata     = glb_rdata;
    rvalid    = rvalid_q;
    busy      = (|req) | (|rvalid_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWNER_RST;
      locked_q <= 1'b0;
      burst_q  <= '0;
      rvalid_q <= '0;
    end else begin
      owner_q  <= owner_d;
      locked_q <= locked_d;
      burst_q  <= burst_d;
      rvalid_q <= gnt;
    end
  end

endmodule

// File: tb/tb_glb_read_arbiter.sv
// Vector-table bench for glb_read_arbiter: same-cycle grants checked directly,
// read returns checked through a one-deep-per-cycle scoreboard queue.
module tb_glb_read_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] addr_in;
  logic [NR-1:0]    gnt;
  logic             glb_re;
  logic [AW-1:0]    glb_addr;
  logic [DW-1:0]    glb_rdata;
  logic [DW-1:0]    rdata;
  logic [NR-1:0]    rvalid;
  logic             busy;

  logic [NR-1:0]    req_b;
  logic [NR*AW-1:0] addr_in_b;
  logic [NR-1:0]    gnt_b;
  logic             glb_re_b;
  logic [AW-1:0]    glb_addr_b;
  logic [DW-1:0]    glb_rdata_b;
  logic [DW-1:0]    rdata_b;
  logic [NR-1:0]    rvalid_b;
  logic             busy_b;

  glb_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .addr_in(addr_in), .gnt(gnt),
    .glb_re(glb_re), .glb_addr(glb_addr), .glb_rdata(glb_rdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  glb_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .addr_in(addr_in_b), .gnt(gnt_b),
    .glb_re(glb_re_b), .glb_addr(glb_addr_b), .glb_rdata(glb_rdata_b),
    .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 20'd37 + 20'd11;
    return t[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] addr_for(input int unsigned i, input logic [11:0] s);
    return (AW'(i) << 12) | AW'(s);
  endfunction

  // GLB memory model: word is a fixed function of the address read.
  always @(posedge clk) begin
    if (glb_re) glb_rdata <= glb_word(glb_addr);
  end

  typedef struct {
    logic [NR-1:0] req;
    logic          rst;
    logic          rst_late;
    logic [NR-1:0] gnt;
  } vec_t;

  typedef struct {
    logic [NR-1:0] rv;
    logic [DW-1:0] data;
  } ret_t;

  vec_t        vecs[$];
  ret_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [11:0] seq = 12'h010;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, n_vec, act, exp);
    end
  endtask

  task automatic add(input logic [NR-1:0] r, input logic rs, input logic rl,
                     input logic [NR-1:0] g, input int n);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.req = r; v.rst = rs; v.rst_late = rl; v.gnt = g;
      vecs.push_back(v);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [AW-1:0] ea;
    ret_t          prev;
    ret_t          nxt;
    reset = v.rst;
    req   = v.req;
    for (int i = 0; i < NR; i++) addr_in[i*AW +: AW] = addr_for(i, seq);
    ea = '0;
    for (int i = 0; i < NR; i++) if (v.gnt[i]) ea = addr_for(i, seq);
    #3;
    n_vec++;
    chk("gnt", 32'(gnt), 32'(v.gnt));
    chk("glb_re", 32'(glb_re), 32'(|v.gnt));
    chk("glb_addr", 32'(glb_addr), 32'(ea));
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      prev = sb.pop_front();
      chk("rvalid", 32'(rvalid), 32'(prev.rv));
      if (prev.rv != '0) chk("rdata", 32'(rdata), 32'(prev.data));
      chk("busy", 32'(busy), 32'((|v.req) | (|prev.rv)));
    end
    if (v.rst_late) reset = 1'b1;
    nxt.rv   = (v.rst || v.rst_late) ? '0 : v.gnt;
    nxt.data = glb_word(ea);
    sb.push_back(nxt);
    seq = seq + 12'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ret_t          z;
    logic [NR-1:0] exp_b;
    logic [NR-1:0] prev_b;
    reset = 1'b1; req = '0; addr_in = '0; glb_rdata = 16'hdead;
    req_b = '0; addr_in_b = '0; glb_rdata_b = '0;
    z.rv = '0; z.data = '0;
    sb.push_back(z);

    // reset held with all requests up, then full contention
    add(3'b111, 1'b1, 1'b0, 3'b000, 3);
    add(3'b111, 1'b0, 1'b0, 3'b001, 4);
    add(3'b111, 1'b0, 1'b0, 3'b010, 4);
    add(3'b111, 1'b0, 1'b0, 3'b100, 4);
    add(3'b111, 1'b0, 1'b0, 3'b001, 2);
    add(3'b000, 1'b0, 1'b0, 3'b000, 1);
    // single requester, no burst cutoff
    add(3'b010, 1'b0, 1'b0, 3'b010, 6);
    // early release with skip over idle requester 1
    add(3'b000, 1'b1, 1'b0, 3'b000, 1);
    add(3'b101, 1'b0, 1'b0, 3'b001, 2);
    add(3'b100, 1'b0, 1'b0, 3'b100, 6);
    // reset during the third grant to requester 1
    add(3'b000, 1'b1, 1'b0, 3'b000, 1);
    add(3'b110, 1'b0, 1'b0, 3'b010, 2);
    add(3'b110, 1'b0, 1'b1, 3'b010, 1);
    add(3'b110, 1'b1, 1'b0, 3'b000, 1);
    add(3'b110, 1'b0, 1'b0, 3'b010, 4);
    add(3'b110, 1'b0, 1'b0, 3'b100, 4);
    add(3'b110, 1'b0, 1'b0, 3'b010, 1);
    add(3'b000, 1'b0, 1'b0, 3'b000, 2);

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    // MAX_BURST=1 instance: strict alternation, single-cycle rvalid pulses
    prev_b = '0;
    exp_b  = 3'b001;
    req_b  = 3'b101;
    for (int k = 0; k < 8; k++) begin
      #3;
      n_vec++;
      chk("gnt_mb1", 32'(gnt_b), 32'(exp_b));
      chk("rvalid_mb1", 32'(rvalid_b), 32'(prev_b));
      prev_b = exp_b;
      exp_b  = (exp_b == 3'b001) ? 3'b100 : 3'b001;
      @(posedge clk);
      #1;
    end
    req_b = '0;
    #3;
    n_vec++;
    chk("rvalid_mb1_tail", 32'(rvalid_b), 32'(prev_b));
    chk("gnt_mb1_idle", 32'(gnt_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/glb_read_arbiter.md
# glb_read_arbiter

Round-robin arbiter that shares the single global-buffer (GLB) read port between the NoC controllers: ifmap, filter and ipsum. Each controller raises a per-cycle read request with an address. The arbiter grants one requester per cycle and drives the GLB read enable and address. One cycle later it returns the read data, tagged with a per-requester valid. A granted requester may hold the port for a bounded burst, which keeps its collector FIFO streaming without starving the others.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (index 0 = ifmap, 1 = filter, 2 = ipsum); must be ≥ 1
- ADDR_WIDTH, 20, GLB address width
- DATA_WIDTH, 16, GLB read data width
- MAX_BURST, 4, maximum consecutive grants to one requester while another is waiting; must be ≥ 1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester read request, level, sampled each cycle
- addr_in  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_REQ  one-hot grant for the current cycle, all-zero if idle
- glb_re  out  1  GLB read enable, equal to |gnt
- glb_addr  out  ADDR_WIDTH  address of the granted requester; 0 when no grant
- glb_rdata  in  DATA_WIDTH  GLB read data, valid one cycle after glb_re
- rdata  out  DATA_WIDTH  glb_rdata passed through, broadcast to all requesters
- rvalid  out  NUM_REQ  one-hot; bit i high means rdata belongs to requester i
- busy  out  1  high while any req is high or any rvalid bit is high

## Operation
- Registered state:
  - owner (index of the last granted requester; reset value NUM_REQ-1, so the first search starts at 0)
  - locked (1 bit; reset value 0)
  - burst_cnt (width clog2(MAX_BURST), minimum 1 bit; reset value 0)
  - rvalid_q (NUM_REQ bits; reset value 0)
- Grant decision is combinational from req and the registered state, evaluated every cycle:
  - Continue: locked=1, req[owner]=1, and either burst_cnt < MAX_BURST-1 or no other req bit set. Grant owner. burst_cnt increments, saturating at MAX_BURST-1.
  - Rotate: otherwise, if any req is set, grant the first set bit searching (owner+1) mod NUM_REQ upward with wrap. Update owner to that index, set burst_cnt=0, set locked=1. If the only set bit is owner itself (after its lock dropped), the search wraps back and grants owner.
  - Idle: no req set. gnt=0, locked←0, owner unchanged, burst_cnt←0.
- A requester removing req mid-burst releases the port the same cycle; there is no penalty cycle.
- Requesters apply their own backpressure: a controller deasserts req when its collector is full. The arbiter never buffers requests or addresses.
- rvalid_q←gnt every cycle. rvalid=rvalid_q. rdata=glb_rdata (combinational).
- Exactly one GLB read is issued per grant. The number of rvalid pulses to requester i equals the number of gnt[i] cycles.

## Timing
- Grant latency: 0 cycles. gnt, glb_re and glb_addr respond in the same cycle req is sampled high.
- Data latency: 1 cycle. rvalid[i] rises on the edge after gnt[i], and rdata holds the corresponding GLB word in that cycle.
- Peak throughput: one read per cycle. Continuous requests under contention are served in runs of MAX_BURST grants per requester, in index order.
- Reset value of every output during and after reset:
  - gnt=0, glb_re=0, glb_addr=0, rvalid=0, busy=0 (as long as req=0)
  - rdata tracks glb_rdata
  - While reset is high, gnt is forced to 0 regardless of req.
- Reset mid-burst: an in-flight rvalid is dropped on the reset edge. After reset, arbitration restarts with requester 0 as highest priority.
- Simultaneous events:
  - The owner dropping req in the same cycle another requester raises it grants the other requester that cycle.
  - When several requesters raise req in the first cycle, the lowest index at or after (owner+1) wins.

## Test plan
- Reset: hold reset 3 cycles with req=3'b111 → gnt=0, glb_re=0, glb_addr=0, rvalid=0 throughout. The first grant after release is gnt=3'b001.
- Single requester: req=3'b010 for 6 cycles, addr_in[1]=0x10..0x15 → gnt=3'b010 for all 6 cycles (no burst cutoff), glb_addr 0x10..0x15, rvalid[1] high for cycles 2–7 carrying the GLB words.
- Full contention (MAX_BURST=4): req=3'b111 continuously for 14 cycles → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,0,0. rvalid mirrors it one cycle later.
- Early release with skip: req0 held 2 cycles, req2 held from cycle 0, req1 low → grants 0,0,2,2,2,2. After that, req2 keeps the grant while it is the sole requester.
- Reset mid-burst: req=3'b110, assert reset in the cycle of the 3rd grant to requester 1 → next cycle gnt=0 and rvalid=0. After release, the first grant goes to requester 1 and burst_cnt restarts at 0.
- MAX_BURST=1, req=3'b101 continuously → grants alternate 0,2,0,2… and each rvalid pulse lasts exactly 1 cycle.
